// File: rtl/mult_div_unit_pkg.sv
// rtl/mult_div_unit_pkg.sv - shared op codes, wide types and FSM state for the multiply/divide unit
package mult_div_unit_pkg;

  typedef logic [5:0]  Vec6;
  typedef logic [31:0] Vec32;
  typedef logic [63:0] Vec64;

  localparam Vec6 MULT  = 6'h18;
  localparam Vec6 MULTU = 6'h19;
  localparam Vec6 DIV   = 6'h1A;
  localparam Vec6 DIVU  = 6'h1B;
  localparam Vec6 MTHI  = 6'h11;
  localparam Vec6 MTLO  = 6'h13;
  localparam Vec6 MADD  = 6'h1C;
  localparam Vec6 MADDU = 6'h1D;
  localparam Vec6 MSUB  = 6'h1E;
  localparam Vec6 MSUBU = 6'h1F;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } MdState;

endpackage

// File: rtl/mdu_divide_step.sv
// rtl/mdu_divide_step.sv - one restoring-division iteration: shift a dividend bit into the remainder, subtract if it fits
module mdu_divide_step
  import mult_div_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] remIn,
  input  logic [XLEN-1:0] quoIn,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] remOut,
  output logic [XLEN-1:0] quoOut
);

  logic [XLEN:0]   shifted;
  logic            fits;
  logic [XLEN-1:0] diff;

  assign shifted = {remIn, quoIn[XLEN-1]};
  assign fits    = shifted >= {1'b0, divisor};
  // Only used when it fits, so the difference always lands inside XLEN bits.
  assign diff    = shifted[XLEN-1:0] - divisor;
  assign remOut  = fits ? diff : shifted[XLEN-1:0];
  assign quoOut  = {quoIn[XLEN-2:0], fits};

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; MDU_MADD_EN adds MADD/MADDU/MSUB/MSUBU
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            mdStart,
  input  logic [5:0]      mdOp,
  input  logic [XLEN-1:0] mdInput1,
  input  logic [XLEN-1:0] mdInput2,
  output logic            mdBusy,
  output logic            mdDone,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  MdState            state, nextState;
  logic [CNT_W-1:0]  cnt;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opB;
  logic              isDiv, negRes, negRem;
  logic              isMulOp, isDivOp, signedOp, startOp;
  logic              neg1, neg2;
  logic [XLEN-1:0]   abs1, abs2;
  logic [XLEN:0]     mulSum;
  logic [2*XLEN-1:0] mulNext;
  logic [XLEN-1:0]   remNext, quoNext;
  logic [XLEN-1:0]   quoFix, remFix;
  logic [2*XLEN-1:0] prodFix, result;
`ifdef MDU_MADD_EN
  logic              isAccOp, accOp, accSub;
`endif

  always_comb begin
    isMulOp  = (mdOp == MULT) || (mdOp == MULTU);
    isDivOp  = (mdOp == DIV) || (mdOp == DIVU);
    signedOp = (mdOp == MULT) || (mdOp == DIV);
`ifdef MDU_MADD_EN
    isAccOp  = (mdOp == MADD) || (mdOp == MADDU) || (mdOp == MSUB) || (mdOp == MSUBU);
    isMulOp  = isMulOp || isAccOp;
    signedOp = signedOp || (mdOp == MADD) || (mdOp == MSUB);
`endif
  end

  assign startOp = mdStart && (state == IDLE) && (isMulOp || isDivOp);
  assign neg1    = signedOp & mdInput1[XLEN-1];
  assign neg2    = signedOp & mdInput2[XLEN-1];
  assign abs1    = neg1 ? -mdInput1 : mdInput1;
  assign abs2    = neg2 ? -mdInput2 : mdInput2;

  // acc = {partial product, remaining multiplier bits}, consumed LSB first
  assign mulSum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opB} : '0);
  assign mulNext = {mulSum, acc[XLEN-1:1]};

  // For divides acc = {remainder, dividend/quotient}
  mdu_divide_step #(.XLEN(XLEN)) divStep (
    .remIn   (acc[2*XLEN-1:XLEN]),
    .quoIn   (acc[XLEN-1:0]),
    .divisor (opB),
    .remOut  (remNext),
    .quoOut  (quoNext)
  );

  // Divide-by-zero needs no special case: the all-ones quotient and the
  // accumulated |dividend| remainder come out right after sign correction.
  assign quoFix  = negRes ? -acc[XLEN-1:0] : acc[XLEN-1:0];
  assign remFix  = negRem ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
  assign prodFix = negRes ? -acc : acc;

  always_comb begin
    result = isDiv ? {remFix, quoFix} : prodFix;
`ifdef MDU_MADD_EN
    if (accOp) result = accSub ? ({hi, lo} - prodFix) : ({hi, lo} + prodFix);
`endif
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (startOp) nextState = CALC;
      CALC:    if (cnt == CNT_W'(XLEN - 1)) nextState = FIX;
      FIX:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  assign mdBusy = (state != IDLE);
  assign mdDone = (state == FIX);

  always_ff @(posedge clk) begin
    if (reset) begin
      hi     <= '0;
      lo     <= '0;
      cnt    <= '0;
      acc    <= '0;
      opB    <= '0;
      isDiv  <= 1'b0;
      negRes <= 1'b0;
      negRem <= 1'b0;
`ifdef MDU_MADD_EN
      accOp  <= 1'b0;
      accSub <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (startOp) begin
            cnt    <= '0;
            isDiv  <= isDivOp;
            negRes <= neg1 ^ neg2;
            negRem <= neg1;
            acc    <= {{XLEN{1'b0}}, isDivOp ? abs1 : abs2};
            opB    <= isDivOp ? abs2 : abs1;
`ifdef MDU_MADD_EN
            accOp  <= isAccOp;
            accSub <= (mdOp == MSUB) || (mdOp == MSUBU);
`endif
          end else if (mdStart && mdOp == MTHI) begin
            hi <= mdInput1;
          end else if (mdStart && mdOp == MTLO) begin
            lo <= mdInput1;
          end
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          acc <= isDiv ? {remNext, quoNext} : mulNext;
        end
        FIX: {hi, lo} <= result;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - self-checking bench for mult_div_unit against an arithmetic reference model
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset, mdStart;
  logic [5:0]  mdOp;
  logic [31:0] mdInput1, mdInput2;
  logic        mdBusy, mdDone;
  logic [31:0] hi, lo;

  int          passCnt = 0;
  int          totalCnt = 0;
  logic [31:0] mHi = '0;
  logic [31:0] mLo = '0;

  always #5 clk = ~clk;

  mult_div_unit dut (
    .clk      (clk),
    .reset    (reset),
    .mdStart  (mdStart),
    .mdOp     (mdOp),
    .mdInput1 (mdInput1),
    .mdInput2 (mdInput2),
    .mdBusy   (mdBusy),
    .mdDone   (mdDone),
    .hi       (hi),
    .lo       (lo)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [63:0] model(input logic [5:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] cur);
    longint sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      MULT:  return 64'(sa * sb);
      MULTU: return ua * ub;
      DIV: begin
        if (b == 0) return {a, (sa >= 0) ? 32'hFFFF_FFFF : 32'h0000_0001};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      DIVU: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
`ifdef MDU_MADD_EN
      MADD:  return cur + 64'(sa * sb);
      MADDU: return cur + ua * ub;
      MSUB:  return cur - 64'(sa * sb);
      MSUBU: return cur - ua * ub;
`endif
      default: return cur;
    endcase
  endfunction

  // Long op; optionally drives a one-cycle start of injOp on busy cycle injAt.
  task automatic runOp(input string tag, input logic [5:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int injAt, input logic [5:0] injOp);
    logic [63:0] exp;
    logic [31:0] hi0, lo0;
    int busyN, doneN;
    logic stable;
    exp = model(op, a, b, {mHi, mLo});
    mdOp = op; mdInput1 = a; mdInput2 = b; mdStart = 1'b1;
    @(posedge clk); #1;
    mdStart = 1'b0; mdInput1 = $urandom; mdInput2 = $urandom;
    hi0 = hi; lo0 = lo; busyN = 0; doneN = 0; stable = 1'b1;
    for (int k = 0; k < 100 && mdBusy; k++) begin
      busyN++;
      if (mdDone) doneN++;
      if (hi !== hi0 || lo !== lo0) stable = 1'b0;
      if (k == injAt) begin
        mdOp = injOp; mdInput1 = 32'hDEAD_BEEF; mdStart = 1'b1;
      end
      @(posedge clk); #1;
      mdStart = 1'b0;
    end
    check({tag, "_busyCycles"}, 64'(busyN), 64'd33);
    check({tag, "_donePulses"}, 64'(doneN), 64'd1);
    check({tag, "_hiloStable"}, 64'(stable), 64'd1);
    check({tag, "_hilo"}, {hi, lo}, exp);
    {mHi, mLo} = exp;
  endtask

  // Single-cycle request that must leave the unit idle.
  task automatic quickOp(input string tag, input logic [5:0] op, input logic [31:0] v);
    mdOp = op; mdInput1 = v; mdInput2 = $urandom; mdStart = 1'b1;
    @(posedge clk); #1;
    mdStart = 1'b0;
    if (op == MTHI) mHi = v;
    if (op == MTLO) mLo = v;
    check({tag, "_busy"}, 64'(mdBusy), 64'd0);
    check({tag, "_done"}, 64'(mdDone), 64'd0);
    check({tag, "_hilo"}, {hi, lo}, {mHi, mLo});
  endtask

  function automatic logic [31:0] pickVal();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [5:0] pickOp();
    case ($urandom_range(0, 5))
      0: return MULT;
      1: return MULTU;
      2: return DIV;
      3: return DIVU;
      4: return MTHI;
      default: return MTLO;
    endcase
  endfunction

  initial begin
    int doneN;
    logic [5:0] op;
    reset = 1'b1; mdStart = 1'b0; mdOp = '0; mdInput1 = '0; mdInput2 = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    check("reset_busy", 64'(mdBusy), 64'd0);
    check("reset_done", 64'(mdDone), 64'd0);

    quickOp("mthi", MTHI, 32'h0000_1234);
    quickOp("mtlo", MTLO, 32'h0000_5678);
    quickOp("unknownOp", 6'h00, 32'h1111_1111);

    runOp("multuMax", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, MTLO);
    check("multuMax_const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    runOp("multNeg", MULT, 32'hFFFF_FFFD, 32'd7, -1, MTLO);
    check("multNeg_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    runOp("divNeg", DIV, 32'hFFFF_FFF9, 32'd2, -1, MTLO);
    check("divNeg_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    runOp("divu", DIVU, 32'd100, 32'd7, -1, MTLO);
    check("divu_const", {hi, lo}, {32'd2, 32'd14});
    runOp("divuZero", DIVU, 32'd5, 32'd0, -1, MTLO);
    check("divuZero_const", {hi, lo}, {32'd5, 32'hFFFF_FFFF});
    runOp("divOvf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, MTLO);
    check("divOvf_const", {hi, lo}, {32'd0, 32'h8000_0000});
    runOp("divZeroNeg", DIV, 32'hFFFF_FFFB, 32'd0, -1, MTLO);
    runOp("divZeroPos", DIV, 32'd7, 32'd0, -1, MTLO);
    runOp("mtloInCalc", MULT, 32'd1234, 32'hFFFF_FF00, 5, MTLO);
    runOp("mthiInFix", DIVU, 32'hFFFF_0000, 32'd3, 32, MTHI);
    runOp("multInCalc", DIV, 32'h7FFF_FFFF, 32'h8000_0000, 31, MULTU);

`ifdef MDU_MADD_EN
    runOp("madd", MADD, 32'hFFFF_FFFE, 32'd3, -1, MTLO);
    runOp("msubu", MSUBU, 32'hFFFF_FFFF, 32'd2, -1, MTLO);
`else
    quickOp("maddIgnored", MADD, 32'h2222_2222);
    quickOp("msubuIgnored", MSUBU, 32'h3333_3333);
`endif

    // Reset in the middle of a multiply
    mdOp = MULT; mdInput1 = 32'h0001_0003; mdInput2 = 32'h0002_0005; mdStart = 1'b1;
    @(posedge clk); #1;
    mdStart = 1'b0;
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    mHi = '0; mLo = '0;
    check("midReset_hilo", {hi, lo}, 64'd0);
    check("midReset_busy", 64'(mdBusy), 64'd0);
    check("midReset_done", 64'(mdDone), 64'd0);
    doneN = 0;
    for (int k = 0; k < 40; k++) begin
      if (mdDone || mdBusy) doneN++;
      @(posedge clk); #1;
    end
    check("midReset_noActivity", 64'(doneN), 64'd0);
    runOp("afterReset", MULTU, 32'h0001_0003, 32'h0002_0005, -1, MTLO);

    for (int i = 0; i < 30; i++) begin
      op = pickOp();
      if (op == MTHI || op == MTLO) quickOp($sformatf("rnd%0d_move", i), op, $urandom);
      else runOp($sformatf("rnd%0d", i), op, pickVal(), pickVal(),
                 $urandom_range(0, 40), pickOp());
    end

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
